mem_stage: RTL and testbench
============================

# mem_stage

Pipeline MEMORY stage, directly downstream of the execute stage. Consumes the EX/MEM pipeline registers, performs aligned byte/half/word loads and stores over a single-outstanding req/ack data-memory bus, and produces the MEM/WB pipeline registers. Asserts a stall to freeze the upstream stages while a bus transaction is in flight. Its `PIP_wb_data_o` is the MEM/WB forwarding operand.

## Interface
- Parameters: none.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `PIP_write_mem_i`, `PIP_read_mem_i` in 1 each: store / load request from EX/MEM.
- `PIP_alu_result_i` in 32: effective address, or the non-memory result.
- `PIP_second_operand_i` in 32: store data (forwarded rs2).
- `PIP_mem_size_i` in 2: access size; 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- `PIP_mem_unsigned_i` in 1: zero-extend loads.
- `PIP_use_mem_i`, `PIP_write_reg_i` in 1 each; `PIP_rd_i` in 5: WB controls.
- `dmem_req_o` out 1; `dmem_we_o` out 1; `dmem_addr_o` out 32 (word aligned, bits [1:0] = 0); `dmem_wdata_o` out 32; `dmem_be_o` out 4: data bus.
- `dmem_rdata_i` in 32; `dmem_ack_i` in 1: bus response, valid in the cycle `dmem_ack_i` = 1.
- `PIP_write_reg_o` out 1; `PIP_rd_o` out 5; `PIP_wb_data_o` out 32: MEM/WB registers.
- `stall_o` out 1: combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- `misaligned_o` out 1: registered one-cycle pulse.

## Operation
- `mem_access` = `PIP_read_mem_i` | `PIP_write_mem_i`. If both are set, it is a load.
- Misaligned access:
  - Condition: half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - No bus request is issued and no stall is raised.
  - MEM/WB gets `PIP_write_reg_o` = 0.
  - `misaligned_o` = 1 for one cycle.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, no access: pass-through in one cycle. `PIP_wb_data_o` ← `PIP_alu_result_i`, controls copied, `stall_o` = 0.
  - IDLE, aligned access: `stall_o` = 1. Register the bus outputs with `dmem_req_o` ← 1. MEM/WB ← bubble (`PIP_write_reg_o` = 0). Next state BUSY.
  - BUSY: `stall_o` = 1; `dmem_req_o` and all bus outputs are held stable.
    - On `dmem_ack_i`: `dmem_req_o` ← 0, capture the formatted load data, next state DONE.
    - Without ack: stay in BUSY, with no timeout.
  - DONE: `stall_o` = 0. MEM/WB ← instruction, with `PIP_wb_data_o` = `PIP_use_mem_i` ? load data : `PIP_alu_result_i`. Next state IDLE, and the upstream stages advance on the same edge.
- EX/MEM inputs are stable while `stall_o` = 1; the block relies on this.
- Store formatting:
  - byte: `dmem_wdata_o` = {4{rs2[7:0]}}, `dmem_be_o` = 4'b0001 << addr[1:0].
  - half: `dmem_wdata_o` = {2{rs2[15:0]}}, `dmem_be_o` = 4'b0011 << {addr[1], 1'b0}.
  - word: `dmem_be_o` = 4'b1111.
- Loads: `dmem_we_o` = 0 and `dmem_be_o` = per size as above. The lane is selected by addr[1:0]; result is sign-extended, or zero-extended if `PIP_mem_unsigned_i`.
- Stores: MEM/WB `PIP_write_reg_o` = `PIP_write_reg_i` (0 from the decoder).
- `dmem_ack_i` outside BUSY is ignored.

## Timing
- Reset values: state IDLE; `dmem_req_o`, `dmem_we_o`, `dmem_addr_o`, `dmem_wdata_o`, `dmem_be_o` all 0; `PIP_write_reg_o`, `PIP_rd_o`, `PIP_wb_data_o`, `misaligned_o` all 0; `stall_o` = 0.
- Reset mid-BUSY: asynchronous return to IDLE and `dmem_req_o` drops immediately. A late ack is ignored.
- Non-memory instruction: 1 cycle.
- Memory instruction: 2 + N cycles, where N ≥ 1 is the number of BUSY cycles including the ack cycle. With ack in the first BUSY cycle, the total is 3 cycles with 2 stall cycles.
- `stall_o` depends on state and current inputs only; it never depends on `dmem_ack_i`.
- Back-to-back memory instructions: DONE → IDLE, then the next request is issued. There is no bubble beyond the IDLE cycle.

## Structure
- `definitions.vh` holds:
  - `MEM_SIZE_B/H/W` codes.
  - `MEM_ST_IDLE/BUSY/DONE` state encodings.
- Sub-module `load_store_align` (combinational):
  - addr[1:0], size, unsigned, rs2, rdata → wdata, be, misaligned flag, extended load data.
- The FSM and pipeline registers live in `mem_stage`.

## Test plan
- ADD result 0x1234, rd = 5, no memory access → next cycle `PIP_wb_data_o` = 0x1234, `PIP_rd_o` = 5, `PIP_write_reg_o` = 1, `stall_o` never 1.
- Signed byte load, addr 0x103, rdata 0x80FF_0000, ack in first BUSY cycle → req at addr 0x100, be = 4'b1000, stall for 2 cycles; then `PIP_wb_data_o` = 0xFFFF_FF80. Unsigned variant → 0x0000_0080.
- Half store, addr 0x202, rs2 = 0xAAAA_BEEF → `dmem_wdata_o` = 0xBEEF_BEEF, be = 4'b1100, `dmem_we_o` = 1. Req held for 3 cycles while ack is delayed 3 cycles; stall lasts 4 cycles.
- Word load at addr 0x101 → no `dmem_req_o`, `misaligned_o` pulse, `PIP_write_reg_o` = 0, no stall.
- `reset_n` asserted in BUSY, then ack on the next cycle → state IDLE, `dmem_req_o` = 0 at once, MEM/WB registers zero, ack ignored.
- Two consecutive word loads, each acked immediately → second req asserts exactly 3 cycles after the first; both results land in MEM/WB in order.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the pipeline MEMORY stage: access-size codes and FSM states.
package mem_stage_pkg;

   localparam logic [1:0] MEM_SIZE_B = 2'd0;
   localparam logic [1:0] MEM_SIZE_H = 2'd1;
   localparam logic [1:0] MEM_SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      MEM_ST_IDLE = 2'd0,
      MEM_ST_BUSY = 2'd1,
      MEM_ST_DONE = 2'd2
   } mem_state_e;

   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, data-memory bus and MEM/WB outputs of the MEMORY stage.
// Bus handshake: dmem_req_o rises with all bus fields valid and holds them
// unchanged until the cycle dmem_ack_i = 1; rdata is only valid in that cycle.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic        PIP_write_mem_i;
   logic        PIP_read_mem_i;
   logic [31:0] PIP_alu_result_i;
   logic [31:0] PIP_second_operand_i;
   logic [1:0]  PIP_mem_size_i;
   logic        PIP_mem_unsigned_i;
   logic        PIP_use_mem_i;
   logic        PIP_write_reg_i;
   logic [4:0]  PIP_rd_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_rdata_i;
   logic        dmem_ack_i;
   logic        PIP_write_reg_o;
   logic [4:0]  PIP_rd_o;
   logic [31:0] PIP_wb_data_o;
   logic        stall_o;
   logic        misaligned_o;
   mem_state_e  dbg_state_o;

   modport slave (
      input  PIP_write_mem_i, PIP_read_mem_i, PIP_alu_result_i, PIP_second_operand_i,
             PIP_mem_size_i, PIP_mem_unsigned_i, PIP_use_mem_i, PIP_write_reg_i, PIP_rd_i,
             dmem_rdata_i, dmem_ack_i,
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
             PIP_write_reg_o, PIP_rd_o, PIP_wb_data_o, stall_o, misaligned_o, dbg_state_o
   );

   modport master (
      output PIP_write_mem_i, PIP_read_mem_i, PIP_alu_result_i, PIP_second_operand_i,
             PIP_mem_size_i, PIP_mem_unsigned_i, PIP_use_mem_i, PIP_write_reg_i, PIP_rd_i,
             dmem_rdata_i, dmem_ack_i,
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
             PIP_write_reg_o, PIP_rd_o, PIP_wb_data_o, stall_o, misaligned_o, dbg_state_o
   );

endinterface

// File: rtl/mem_stage_load_store_align.sv
// Combinational lane steering: store replication/byte enables, alignment check
// and sign/zero extension of the addressed load lane.
module load_store_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_rs2,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_be,
   output logic        o_misaligned,
   output logic [31:0] o_load_data
);

   logic [31:0] w_shifted;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
   assign w_byte    = w_shifted[7:0];
   assign w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_wdata      = i_rs2;
      o_be         = 4'b1111;
      o_misaligned = 1'b0;
      o_load_data  = i_rdata;
      case (i_size)
         MEM_SIZE_B: begin
            o_wdata     = {4{i_rs2[7:0]}};
            o_be        = 4'b0001 << i_addr_lo;
            o_load_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         MEM_SIZE_H: begin
            o_wdata      = {2{i_rs2[15:0]}};
            o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_misaligned = i_addr_lo[0];
            o_load_data  = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         end
         // Word and the reserved code both behave as a full-word access.
         default: begin
            o_misaligned = (i_addr_lo != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEMORY stage: single-outstanding req/ack data bus access with
// upstream stall, producing the MEM/WB registers.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   mem_stage_if.slave  bus
);

   mem_state_e  r_state, w_next;
   logic        r_req, r_we;
   logic [31:0] r_addr, r_wdata, r_load_data;
   logic [3:0]  r_be;
   logic        r_write_reg, r_mis;
   logic [4:0]  r_rd;
   logic [31:0] r_wb_data;

   logic        w_access, w_store, w_stall;
   logic        w_mis;
   logic [31:0] w_wdata, w_load_data;
   logic [3:0]  w_be;

   // A simultaneous read and write request is a load.
   assign w_access = bus.PIP_read_mem_i | bus.PIP_write_mem_i;
   assign w_store  = bus.PIP_write_mem_i & ~bus.PIP_read_mem_i;

   load_store_align u_align (
      .i_addr_lo    (bus.PIP_alu_result_i[1:0]),
      .i_size       (bus.PIP_mem_size_i),
      .i_unsigned   (bus.PIP_mem_unsigned_i),
      .i_rs2        (bus.PIP_second_operand_i),
      .i_rdata      (bus.dmem_rdata_i),
      .o_wdata      (w_wdata),
      .o_be         (w_be),
      .o_misaligned (w_mis),
      .o_load_data  (w_load_data)
   );

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         MEM_ST_IDLE: begin
            if (w_access && !w_mis) begin
               w_stall = 1'b1;
               w_next  = MEM_ST_BUSY;
            end
         end
         MEM_ST_BUSY: begin
            w_stall = 1'b1;
            if (bus.dmem_ack_i) w_next = MEM_ST_DONE;
         end
         MEM_ST_DONE: w_next = MEM_ST_IDLE;
         default:     w_next = MEM_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= MEM_ST_IDLE;
      else          r_state <= w_next;
   end

   // Bus outputs are loaded once on issue and held until the ack.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_be        <= 4'h0;
         r_load_data <= 32'h0;
      end else begin
         case (r_state)
            MEM_ST_IDLE: begin
               if (w_access && !w_mis) begin
                  r_req   <= 1'b1;
                  r_we    <= w_store;
                  r_addr  <= word_addr(bus.PIP_alu_result_i);
                  r_wdata <= w_wdata;
                  r_be    <= w_be;
               end
            end
            MEM_ST_BUSY: begin
               if (bus.dmem_ack_i) begin
                  r_req       <= 1'b0;
                  r_load_data <= w_load_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_write_reg <= 1'b0;
         r_rd        <= 5'd0;
         r_wb_data   <= 32'h0;
         r_mis       <= 1'b0;
      end else begin
         r_mis <= 1'b0;
         case (r_state)
            MEM_ST_IDLE: begin
               if (!w_access || w_mis) begin
                  r_write_reg <= bus.PIP_write_reg_i & ~w_access;
                  r_rd        <= bus.PIP_rd_i;
                  r_wb_data   <= bus.PIP_alu_result_i;
                  r_mis       <= w_access;
               end else begin
                  r_write_reg <= 1'b0;
               end
            end
            MEM_ST_DONE: begin
               r_write_reg <= bus.PIP_write_reg_i;
               r_rd        <= bus.PIP_rd_i;
               r_wb_data   <= bus.PIP_use_mem_i ? r_load_data : bus.PIP_alu_result_i;
            end
            default: r_write_reg <= 1'b0;
         endcase
      end
   end

   assign bus.stall_o         = w_stall & reset_n;
   assign bus.dmem_req_o      = r_req;
   assign bus.dmem_we_o       = r_we;
   assign bus.dmem_addr_o     = r_addr;
   assign bus.dmem_wdata_o    = r_wdata;
   assign bus.dmem_be_o       = r_be;
   assign bus.PIP_write_reg_o = r_write_reg;
   assign bus.PIP_rd_o        = r_rd;
   assign bus.PIP_wb_data_o   = r_wb_data;
   assign bus.misaligned_o    = r_mis;
   assign bus.dbg_state_o     = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage plus reset-in-BUSY and
// back-to-back load sequences.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   last_req_cyc = 0;

   mem_stage_if bus();

   mem_stage u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        rd_mem;
      logic        wr_mem;
      logic [31:0] addr;
      logic [31:0] rs2;
      logic [1:0]  size;
      logic        uns;
      logic        use_mem;
      logic        wreg;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          ack_delay;
      logic [31:0] e_addr;
      logic        e_we;
      logic [31:0] e_wdata;
      logic [3:0]  e_be;
      logic [31:0] e_wb;
      logic        e_wreg;
      logic [4:0]  e_rd;
      logic        chk_wb;
      logic        e_mis;
      int          e_stalls;
      int          e_reqs;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.PIP_read_mem_i       = v.rd_mem;
      bus.PIP_write_mem_i      = v.wr_mem;
      bus.PIP_alu_result_i     = v.addr;
      bus.PIP_second_operand_i = v.rs2;
      bus.PIP_mem_size_i       = v.size;
      bus.PIP_mem_unsigned_i   = v.uns;
      bus.PIP_use_mem_i        = v.use_mem;
      bus.PIP_write_reg_i      = v.wreg;
      bus.PIP_rd_i             = v.rd;
      bus.dmem_rdata_i         = v.rdata;
      bus.dmem_ack_i           = 1'b0;
   endtask

   // Holds one instruction until the stage stops stalling, acking after
   // ack_delay request cycles, then checks bus fields and MEM/WB results.
   task automatic run_vec(input int idx, input vec_t v);
      int  stalls = 0;
      int  reqs = 0;
      int  budget = 0;
      bit  done = 1'b0;
      bit  first = 1'b1;
      string p = $sformatf("v%0d_", idx);
      drive(v);
      while (!done) begin
         @(negedge clk);
         if (bus.stall_o) stalls++;
         if (bus.dmem_req_o) begin
            reqs++;
            if (first) begin
               first = 1'b0;
               last_req_cyc = cyc;
               chk({p, "addr"}, bus.dmem_addr_o, v.e_addr);
               chk({p, "we"}, 32'(bus.dmem_we_o), 32'(v.e_we));
               chk({p, "be"}, 32'(bus.dmem_be_o), 32'(v.e_be));
               if (v.e_we) chk({p, "wdata"}, bus.dmem_wdata_o, v.e_wdata);
            end
            bus.dmem_ack_i = (reqs >= v.ack_delay);
         end else begin
            bus.dmem_ack_i = 1'b0;
         end
         done = !bus.stall_o;
         budget++;
         if (budget > 40) begin
            chk({p, "timeout"}, 32'(budget), 32'd40);
            done = 1'b1;
         end
         @(posedge clk);
      end
      #1;
      bus.dmem_ack_i = 1'b0;
      chk({p, "stalls"}, 32'(stalls), 32'(v.e_stalls));
      chk({p, "reqs"}, 32'(reqs), 32'(v.e_reqs));
      chk({p, "wreg"}, 32'(bus.PIP_write_reg_o), 32'(v.e_wreg));
      chk({p, "mis"}, 32'(bus.misaligned_o), 32'(v.e_mis));
      chk({p, "state"}, 32'(bus.dbg_state_o), 32'(MEM_ST_IDLE));
      if (v.chk_wb) begin
         chk({p, "wb"}, bus.PIP_wb_data_o, v.e_wb);
         chk({p, "rd"}, 32'(bus.PIP_rd_o), 32'(v.e_rd));
      end
   endtask

   task automatic chk_all_zero(input string p);
      chk({p, "req"}, 32'(bus.dmem_req_o), 32'd0);
      chk({p, "we"}, 32'(bus.dmem_we_o), 32'd0);
      chk({p, "addr"}, bus.dmem_addr_o, 32'd0);
      chk({p, "wdata"}, bus.dmem_wdata_o, 32'd0);
      chk({p, "be"}, 32'(bus.dmem_be_o), 32'd0);
      chk({p, "wreg"}, 32'(bus.PIP_write_reg_o), 32'd0);
      chk({p, "rd"}, 32'(bus.PIP_rd_o), 32'd0);
      chk({p, "wb"}, bus.PIP_wb_data_o, 32'd0);
      chk({p, "mis"}, 32'(bus.misaligned_o), 32'd0);
      chk({p, "stall"}, 32'(bus.stall_o), 32'd0);
      chk({p, "state"}, 32'(bus.dbg_state_o), 32'(MEM_ST_IDLE));
   endtask

   initial begin
      vec_t va, vb;
      int   t_first;
      // rd wr addr rs2 size uns use wreg rd rdata ack | e_addr we wdata be wb wreg rd chk mis stalls reqs
      vecs[0]  = '{1'b0,1'b0,32'h0000_1234,32'h0,2'd2,1'b0,1'b0,1'b1,5'd5,32'h0,1,
                   32'h0,1'b0,32'h0,4'h0,32'h0000_1234,1'b1,5'd5,1'b1,1'b0,0,0};
      vecs[1]  = '{1'b1,1'b0,32'h0000_0103,32'h0,2'd0,1'b0,1'b1,1'b1,5'd6,32'h80FF_0000,1,
                   32'h0000_0100,1'b0,32'h0,4'b1000,32'hFFFF_FF80,1'b1,5'd6,1'b1,1'b0,2,1};
      vecs[2]  = '{1'b1,1'b0,32'h0000_0103,32'h0,2'd0,1'b1,1'b1,1'b1,5'd7,32'h80FF_0000,1,
                   32'h0000_0100,1'b0,32'h0,4'b1000,32'h0000_0080,1'b1,5'd7,1'b1,1'b0,2,1};
      vecs[3]  = '{1'b0,1'b1,32'h0000_0202,32'hAAAA_BEEF,2'd1,1'b0,1'b0,1'b0,5'd0,32'h0,3,
                   32'h0000_0200,1'b1,32'hBEEF_BEEF,4'b1100,32'h0000_0202,1'b0,5'd0,1'b1,1'b0,4,3};
      vecs[4]  = '{1'b1,1'b0,32'h0000_0101,32'h0,2'd2,1'b0,1'b1,1'b1,5'd8,32'h0,1,
                   32'h0,1'b0,32'h0,4'h0,32'h0,1'b0,5'd8,1'b0,1'b1,0,0};
      vecs[5]  = '{1'b1,1'b0,32'h0000_0302,32'h0,2'd1,1'b0,1'b1,1'b1,5'd10,32'h8001_1234,2,
                   32'h0000_0300,1'b0,32'h0,4'b1100,32'hFFFF_8001,1'b1,5'd10,1'b1,1'b0,3,2};
      vecs[6]  = '{1'b1,1'b0,32'h0000_0300,32'h0,2'd1,1'b1,1'b1,1'b1,5'd11,32'h8001_F00D,1,
                   32'h0000_0300,1'b0,32'h0,4'b0011,32'h0000_F00D,1'b1,5'd11,1'b1,1'b0,2,1};
      vecs[7]  = '{1'b0,1'b1,32'h0000_0401,32'h1234_56A5,2'd0,1'b0,1'b0,1'b0,5'd0,32'h0,1,
                   32'h0000_0400,1'b1,32'hA5A5_A5A5,4'b0010,32'h0000_0401,1'b0,5'd0,1'b1,1'b0,2,1};
      vecs[8]  = '{1'b0,1'b1,32'h0000_0500,32'hDEAD_BEEF,2'd2,1'b0,1'b0,1'b0,5'd0,32'h0,1,
                   32'h0000_0500,1'b1,32'hDEAD_BEEF,4'b1111,32'h0000_0500,1'b0,5'd0,1'b1,1'b0,2,1};
      vecs[9]  = '{1'b1,1'b0,32'h0000_0600,32'h0,2'd2,1'b0,1'b1,1'b1,5'd12,32'hCAFE_F00D,4,
                   32'h0000_0600,1'b0,32'h0,4'b1111,32'hCAFE_F00D,1'b1,5'd12,1'b1,1'b0,5,4};
      vecs[10] = '{1'b1,1'b1,32'h0000_0604,32'hFFFF_FFFF,2'd2,1'b0,1'b1,1'b1,5'd13,32'h1122_3344,1,
                   32'h0000_0604,1'b0,32'h0,4'b1111,32'h1122_3344,1'b1,5'd13,1'b1,1'b0,2,1};
      vecs[11] = '{1'b1,1'b0,32'h0000_0207,32'h0,2'd1,1'b0,1'b1,1'b1,5'd14,32'h0,1,
                   32'h0,1'b0,32'h0,4'h0,32'h0,1'b0,5'd14,1'b0,1'b1,0,0};
      vecs[12] = '{1'b1,1'b0,32'h0000_0700,32'h0,2'd3,1'b0,1'b1,1'b1,5'd14,32'h5566_7788,1,
                   32'h0000_0700,1'b0,32'h0,4'b1111,32'h5566_7788,1'b1,5'd14,1'b1,1'b0,2,1};
      vecs[13] = '{1'b1,1'b0,32'h0000_0708,32'h0,2'd2,1'b0,1'b0,1'b1,5'd15,32'h9999_9999,1,
                   32'h0000_0708,1'b0,32'h0,4'b1111,32'h0000_0708,1'b1,5'd15,1'b1,1'b0,2,1};
      vecs[14] = '{1'b0,1'b0,32'hFFFF_FFFF,32'h0,2'd2,1'b0,1'b0,1'b1,5'd31,32'h0,1,
                   32'h0,1'b0,32'h0,4'h0,32'hFFFF_FFFF,1'b1,5'd31,1'b1,1'b0,0,0};

      // Reset state, with a word load presented so stall gating is visible.
      va = vecs[9];
      drive(va);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("rst_");
      va.rd_mem = 1'b0;
      drive(va);
      reset_n = 1'b1;

      for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

      // Reset while a load waits in BUSY; a late ack must be ignored.
      va = vecs[9];
      va.addr = 32'h0000_0800;
      drive(va);
      @(posedge clk);
      @(negedge clk);
      chk("rb_req_before", 32'(bus.dmem_req_o), 32'd1);
      chk("rb_state_before", 32'(bus.dbg_state_o), 32'(MEM_ST_BUSY));
      #1 reset_n = 1'b0;
      #1 chk_all_zero("rb_");
      @(posedge clk);
      #1;
      va = vecs[0];
      va.addr = 32'h0;
      va.wreg = 1'b0;
      va.rd = 5'd0;
      drive(va);
      bus.dmem_ack_i = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      bus.dmem_ack_i = 1'b0;
      chk("rb_late_state", 32'(bus.dbg_state_o), 32'(MEM_ST_IDLE));
      chk("rb_late_req", 32'(bus.dmem_req_o), 32'd0);
      chk("rb_late_wreg", 32'(bus.PIP_write_reg_o), 32'd0);

      // Back-to-back word loads: second request three cycles after the first.
      va = vecs[9];
      va.addr = 32'h0000_0900; va.rdata = 32'h0A0A_0A0A; va.rd = 5'd16; va.ack_delay = 1;
      va.e_addr = 32'h0000_0900; va.e_wb = 32'h0A0A_0A0A; va.e_rd = 5'd16;
      va.e_stalls = 2; va.e_reqs = 1;
      vb = va;
      vb.addr = 32'h0000_0904; vb.rdata = 32'h0B0B_0B0B; vb.rd = 5'd17;
      vb.e_addr = 32'h0000_0904; vb.e_wb = 32'h0B0B_0B0B; vb.e_rd = 5'd17;
      run_vec(100, va);
      t_first = last_req_cyc;
      run_vec(101, vb);
      chk("b2b_gap", 32'(last_req_cyc - t_first), 32'd3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
